// File: rtl/instr_issue_if.sv
// instr_issue_if: fetch-side handshake, ALU issue fields and completion strobes for the issue stage.
interface instr_issue_if;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] alu_ir;
  logic [31:0] alu_pc;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        state;
  logic        load_regfile;
  logic        jump_dv;
  logic        mem_done;
  logic        retire;
  logic        illegal;
  logic        timeout;
  modport master (
    output ir_valid, ir, pc, load_regfile, jump_dv, mem_done,
    input  ir_ready, instruction, alu_ir, alu_pc, rs1, rs2, rd, state, retire, illegal, timeout
  );
  modport slave (
    input  ir_valid, ir, pc, load_regfile, jump_dv, mem_done,
    output ir_ready, instruction, alu_ir, alu_pc, rs1, rs2, rd, state, retire, illegal, timeout
  );
endinterface

// File: rtl/instr_issue.sv
// instr_issue: RV32IM decode-and-issue stage; issues one ALU op code, then waits for its completion.
module instr_issue #(
  parameter int TIMEOUT  = 64,
  parameter int NOP_CODE = 63
) (
  input logic           clk,
  input logic           rst_n,
  instr_issue_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t st, nxt;
  logic [5:0] dec, code;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [CW-1:0] cnt;
  logic legal, acc, done, to, busy, is_div, is_mem, is_br;
  logic unused;
  assign op = bus.ir[6:0];
  assign f3 = bus.ir[14:12];
  assign f7 = bus.ir[31:25];
  // branches retire on their own; the taken-jump strobe only matters to the ALU
  assign unused = bus.jump_dv;
  always_comb begin
    dec = '0;
    legal = 1'b0;
    case (op)
      7'b0110011: begin
        legal = f7 == 7'h00 || f7 == 7'h01 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        dec = f7 == 7'h01 ? 6'd10 + 6'(f3) :
              f7 == 7'h20 ? (f3 == 3'd0 ? 6'd1 : 6'd7) :
              f3 == 3'd0  ? 6'd0 : f3 < 3'd6 ? 6'(f3) + 6'd1 : 6'(f3) + 6'd2;
      end
      7'b0010011: begin
        legal = f3 == 3'd1 ? f7 == 7'h00 : f3 == 3'd5 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        dec = f3 == 3'd0 ? 6'd18 : f3 == 3'd1 ? 6'd24 :
              f3 == 3'd5 ? (f7[5] ? 6'd26 : 6'd25) :
              f3 < 3'd5  ? 6'(f3) + 6'd17 : 6'(f3) + 6'd16;
      end
      7'b0000011: begin
        legal = f3 != 3'd3 && f3 < 3'd6;
        dec = f3 < 3'd3 ? 6'd27 + 6'(f3) : 6'd26 + 6'(f3);
      end
      7'b0100011: begin
        legal = f3 < 3'd3;
        dec = 6'd32 + 6'(f3);
      end
      7'b1100011: begin
        legal = f3 != 3'd2 && f3 != 3'd3;
        dec = f3 < 3'd2 ? 6'd35 + 6'(f3) : 6'd33 + 6'(f3);
      end
      7'b1101111: begin
        legal = 1'b1;
        dec = 6'd41;
      end
      7'b1100111: begin
        legal = f3 == 3'd0;
        dec = 6'd42;
      end
      7'b0110111: begin
        legal = 1'b1;
        dec = 6'd43;
      end
      7'b0010111: begin
        legal = 1'b1;
        dec = 6'd44;
      end
      default: legal = 1'b0;
    endcase
  end
  assign is_div = code >= 6'd14 && code <= 6'd17;
  assign is_mem = code >= 6'd27 && code <= 6'd34;
  assign is_br  = code >= 6'd35 && code <= 6'd40;
  assign acc = st == IDLE && bus.ir_valid && bus.ir_ready;
  always_comb begin
    nxt = st;
    done = 1'b0;
    to = 1'b0;
    case (st)
      IDLE:  nxt = acc && legal ? ISSUE : IDLE;
      ISSUE: nxt = WAIT;
      WAIT: begin
        done = is_br || (is_mem ? bus.mem_done : bus.load_regfile);
        to = !done && cnt == CW'(TIMEOUT - 1);
        nxt = done || to ? IDLE : WAIT;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      code <= '0;
      cnt <= '0;
      busy <= 1'b0;
      bus.alu_ir <= '0;
      bus.alu_pc <= '0;
      bus.rs1 <= '0;
      bus.rs2 <= '0;
      bus.rd <= '0;
      bus.retire <= 1'b0;
      bus.illegal <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= st == WAIT ? cnt + 1'b1 : '0;
      bus.retire <= done;
      bus.illegal <= acc && !legal;
      bus.timeout <= to;
      // divide flag drops one cycle after retire/abort so the ALU counter clears late
      busy <= acc && legal ? (dec >= 6'd14 && dec <= 6'd17) : (bus.retire || bus.timeout) ? 1'b0 : busy;
      if (acc) begin
        code <= dec;
        bus.alu_ir <= bus.ir;
        bus.alu_pc <= bus.pc;
        bus.rs1 <= bus.ir[19:15];
        bus.rs2 <= bus.ir[24:20];
        bus.rd <= bus.ir[11:7];
      end
    end
  end
  assign bus.ir_ready = st == IDLE && !bus.illegal;
  assign bus.state = busy;
  assign bus.instruction = 32'((st == ISSUE || (st == WAIT && is_div)) ? code : 6'(NOP_CODE));
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: table-driven decode/retire vectors plus hand sequences for divide, timeout and reset.
module tb_instr_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  instr_issue_if bus();
  instr_issue dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] ir;
    logic [5:0]  code;
    logic        legal;
    logic [1:0]  src;
  } vec_t;
  vec_t vq[$];
  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(bus.ir_ready), 1);
    chk({tag, "_instr"}, bus.instruction, 63);
    chk({tag, "_ir"}, bus.alu_ir, 0);
    chk({tag, "_pc"}, bus.alu_pc, 0);
    chk({tag, "_idx"}, {17'd0, bus.rs1, bus.rs2, bus.rd}, 0);
    chk({tag, "_flags"}, {28'd0, bus.state, bus.retire, bus.illegal, bus.timeout}, 0);
  endtask
  task automatic accept(input logic [31:0] ir, input logic [31:0] pc);
    @(negedge clk);
    bus.ir_valid = 1'b1;
    bus.ir = ir;
    bus.pc = pc;
    @(posedge clk);
    @(negedge clk);
    bus.ir_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.ir_valid = 1'b0;
    bus.ir = '0;
    bus.pc = '0;
    bus.load_regfile = 1'b0;
    bus.jump_dv = 1'b0;
    bus.mem_done = 1'b0;
    vq.push_back('{enc(7'h00, 3'd0, 7'h33), 6'd0,  1'b1, 2'd0});
    vq.push_back('{enc(7'h20, 3'd0, 7'h33), 6'd1,  1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd1, 7'h33), 6'd2,  1'b1, 2'd0});
    vq.push_back('{enc(7'h20, 3'd5, 7'h33), 6'd7,  1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd7, 7'h33), 6'd9,  1'b1, 2'd0});
    vq.push_back('{enc(7'h01, 3'd0, 7'h33), 6'd10, 1'b1, 2'd0});
    vq.push_back('{enc(7'h01, 3'd3, 7'h33), 6'd13, 1'b1, 2'd0});
    vq.push_back('{enc(7'h20, 3'd1, 7'h33), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h02, 3'd0, 7'h33), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h00, 3'd1, 7'h13), 6'd24, 1'b1, 2'd0});
    vq.push_back('{enc(7'h20, 3'd5, 7'h13), 6'd26, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd5, 7'h13), 6'd25, 1'b1, 2'd0});
    vq.push_back('{enc(7'h20, 3'd1, 7'h13), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h7F, 3'd6, 7'h13), 6'd22, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd3, 7'h13), 6'd20, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd4, 7'h03), 6'd30, 1'b1, 2'd1});
    vq.push_back('{enc(7'h00, 3'd2, 7'h03), 6'd29, 1'b1, 2'd1});
    vq.push_back('{enc(7'h00, 3'd3, 7'h03), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h00, 3'd1, 7'h23), 6'd33, 1'b1, 2'd1});
    vq.push_back('{32'h00112023,            6'd34, 1'b1, 2'd1});
    vq.push_back('{enc(7'h00, 3'd3, 7'h23), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h00, 3'd7, 7'h63), 6'd40, 1'b1, 2'd2});
    vq.push_back('{enc(7'h00, 3'd4, 7'h63), 6'd37, 1'b1, 2'd2});
    vq.push_back('{enc(7'h00, 3'd2, 7'h63), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h00, 3'd0, 7'h6F), 6'd41, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd0, 7'h67), 6'd42, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd1, 7'h67), 6'd63, 1'b0, 2'd0});
    vq.push_back('{enc(7'h12, 3'd0, 7'h37), 6'd43, 1'b1, 2'd0});
    vq.push_back('{enc(7'h00, 3'd0, 7'h17), 6'd44, 1'b1, 2'd0});
    vq.push_back('{32'hFFFFFFFF,            6'd63, 1'b0, 2'd0});
    vq.push_back('{32'h00000000,            6'd63, 1'b0, 2'd0});
    #1 rst_n = 1'b0;
    #11;
    reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // completion strobes while idle must not retire anything
    @(negedge clk);
    bus.load_regfile = 1'b1;
    bus.mem_done = 1'b1;
    bus.jump_dv = 1'b1;
    @(negedge clk);
    bus.load_regfile = 1'b0;
    bus.mem_done = 1'b0;
    bus.jump_dv = 1'b0;
    chk("idle_no_retire", 32'(bus.retire), 0);
    chk("idle_ready", 32'(bus.ir_ready), 1);
    foreach (vq[i]) begin
      accept(vq[i].ir, 32'h1000 + 32'(i) * 4);
      if (vq[i].legal) begin
        chk($sformatf("v%0d_code", i), bus.instruction, 32'(vq[i].code));
        chk($sformatf("v%0d_ir", i), bus.alu_ir, vq[i].ir);
        chk($sformatf("v%0d_pc", i), bus.alu_pc, 32'h1000 + 32'(i) * 4);
        if (vq[i].ir != 32'h00112023)
          chk($sformatf("v%0d_idx", i), {17'd0, bus.rs1, bus.rs2, bus.rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk($sformatf("v%0d_busy", i), {30'd0, bus.ir_ready, bus.illegal}, 0);
        @(negedge clk);
        chk($sformatf("v%0d_wait_nop", i), bus.instruction, 63);
        bus.load_regfile = vq[i].src != 2'd2;
        @(negedge clk);
        bus.load_regfile = 1'b0;
        if (vq[i].src == 2'd1) begin
          chk($sformatf("v%0d_mem_not_yet", i), 32'(bus.retire), 0);
          bus.mem_done = 1'b1;
          @(negedge clk);
          bus.mem_done = 1'b0;
        end
        chk($sformatf("v%0d_retire", i), {29'd0, bus.retire, bus.ir_ready, bus.timeout}, 32'b110);
        @(negedge clk);
        chk($sformatf("v%0d_retire_pulse", i), 32'(bus.retire), 0);
      end else begin
        chk($sformatf("v%0d_illegal", i), {28'd0, bus.illegal, bus.ir_ready, bus.retire, bus.state}, 32'b1000);
        chk($sformatf("v%0d_ill_nop", i), bus.instruction, 63);
        @(negedge clk);
        chk($sformatf("v%0d_ill_after", i), {29'd0, bus.illegal, bus.ir_ready, bus.retire}, 32'b010);
        chk($sformatf("v%0d_ill_nop2", i), bus.instruction, 63);
      end
    end
    accept(32'h027342B3, 32'h2000);
    chk("div_code", bus.instruction, 14);
    chk("div_state", 32'(bus.state), 1);
    chk("div_idx", {17'd0, bus.rs1, bus.rs2, bus.rd}, {17'd0, 5'd6, 5'd7, 5'd5});
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      chk("div_hold", bus.instruction, 14);
      chk("div_hold_state", {30'd0, bus.state, bus.retire}, 32'b10);
      if (k == 26) bus.load_regfile = 1'b1;
    end
    @(negedge clk);
    bus.load_regfile = 1'b0;
    chk("div_retire", {30'd0, bus.retire, bus.state}, 32'b11);
    chk("div_retire_nop", bus.instruction, 63);
    @(negedge clk);
    chk("div_state_fall", {30'd0, bus.state, bus.retire}, 0);
    accept(32'h027342B3, 32'h2004);
    chk("div2_code", bus.instruction, 14);
    chk("div2_state", 32'(bus.state), 1);
    repeat (3) @(negedge clk);
    chk("div2_wait", bus.instruction, 14);
    #2 rst_n = 1'b0;
    #1;
    reset_outs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_retire", 32'(bus.retire), 0);
    accept(32'h00000463, 32'h3000);
    chk("beq_code", bus.instruction, 35);
    @(negedge clk);
    bus.jump_dv = 1'b1;
    chk("beq_nop", {31'd0, bus.retire}, 0);
    @(negedge clk);
    bus.jump_dv = 1'b0;
    chk("beq_retire", {30'd0, bus.retire, bus.ir_ready}, 32'b11);
    accept(32'h008000EF, 32'h4000);
    chk("jal_code", bus.instruction, 41);
    begin
      int k;
      k = 0;
      while (!bus.timeout && !bus.retire && k < 200) begin
        @(negedge clk);
        k++;
      end
      chk("timeout_cycles", 32'(k), 65);
      chk("timeout_flags", {29'd0, bus.timeout, bus.retire, bus.ir_ready}, 32'b101);
    end
    @(negedge clk);
    chk("timeout_pulse", 32'(bus.timeout), 0);
    accept(32'h002081B3, 32'h5000);
    chk("late_add_code", bus.instruction, 0);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 64) begin
        chk("late_add_pending", {30'd0, bus.retire, bus.timeout}, 0);
        bus.load_regfile = 1'b1;
      end
    end
    @(negedge clk);
    bus.load_regfile = 1'b0;
    chk("late_add_wins", {30'd0, bus.retire, bus.timeout}, 32'b10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
